// File: rtl/serial_deshifter.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB first, optional even parity,
// stop bit. Define SERIAL_DESHIFTER_PARITY_EN to add the parity stage.
module serial_deshifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             D,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SERIAL_DESHIFTER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StPar, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;
`endif

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]  r_shift, w_shift_d;
  logic [WIDTH-1:0]  r_data, w_data_d;
  logic              r_valid, w_valid_d;
  logic              r_err, w_err_d;
  logic              w_stop_ok;

`ifdef SERIAL_DESHIFTER_PARITY_EN
  logic              r_par_err, w_par_err_d;
  assign w_stop_ok = D & ~r_par_err;
`else
  assign w_stop_ok = D;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shift_d = r_shift;
    w_data_d  = r_data;
    w_valid_d = 1'b0;
    w_err_d   = 1'b0;
`ifdef SERIAL_DESHIFTER_PARITY_EN
    w_par_err_d = r_par_err;
`endif
    if (EN) begin
      case (r_state)
        StIdle: begin
          if (!D) begin
            w_state_d = StData;
            w_cnt_d   = '0;
          end
        end
        StData: begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_cnt == CntW'(i)) w_shift_d[i] = D;
          end
          if (r_cnt == CntW'(WIDTH - 1)) begin
            w_cnt_d = '0;
`ifdef SERIAL_DESHIFTER_PARITY_EN
            w_state_d = StPar;
`else
            w_state_d = StStop;
`endif
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
`ifdef SERIAL_DESHIFTER_PARITY_EN
        StPar: begin
          // Even parity: payload bits plus parity bit must XOR to zero.
          w_par_err_d = (^r_shift) ^ D;
          w_state_d   = StStop;
        end
`endif
        StStop: begin
          if (w_stop_ok) begin
            w_data_d  = r_shift;
            w_valid_d = 1'b1;
          end else begin
            w_err_d = 1'b1;
          end
          w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
    end
  end

`ifdef SERIAL_DESHIFTER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err <= 1'b0;
    else        r_par_err <= w_par_err_d;
  end
`endif

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_serial_deshifter.sv
// Self-checking bench for serial_deshifter (WIDTH=8): frame table plus reset/idle sequences,
// with a scoreboard of expected valid/frame_err pulses.
module tb_serial_deshifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       EN = 1'b0;
  logic       D = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_fail = 0;
  int seed = 32'h5eed;

  typedef struct {
    logic [7:0] pl;
    logic       par;
    logic       stp;
    int         gmax;
  } vec_t;

  typedef struct {
    logic       ok;
    logic [7:0] d;
  } exp_t;

  vec_t       tbl[8];
  exp_t       sbq[$];
  logic [7:0] model_data = 8'h00;

  serial_deshifter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .EN       (EN),
    .D        (D),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every pulse must match the oldest expected frame outcome.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_valid", {31'd0, valid}, {31'd0, e.ok});
        check("pulse_err", {31'd0, frame_err}, {31'd0, ~e.ok});
        check("pulse_data", {24'd0, data}, {24'd0, e.d});
      end
    end
  end

  task automatic send_bit(input logic b, input int gmax);
    int gap;
    gap = (gmax > 0) ? int'($unsigned($random(seed)) % (gmax + 1)) : 0;
    repeat (gap) begin
      @(negedge clk);
      EN = 1'b0;
      D  = 1'($urandom);
    end
    @(negedge clk);
    EN = 1'b1;
    D  = b;
  endtask

  task automatic send_frame(input logic [7:0] pl, input logic par, input logic stp,
                            input int gmax);
    exp_t e;
    logic ok;
    send_bit(1'b0, gmax);
    for (int i = 0; i < 8; i++) send_bit(pl[i], gmax);
`ifdef SERIAL_DESHIFTER_PARITY_EN
    send_bit(par, gmax);
    ok = stp & ~((^pl) ^ par);
`else
    ok = stp;
`endif
    if (ok) model_data = pl;
    e.ok = ok;
    e.d  = model_data;
    sbq.push_back(e);
    send_bit(stp, gmax);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      EN = 1'b0;
      D  = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(name, sbq.size(), 32'd0);
  endtask

  initial begin
    //          payload  par   stop  gaps
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 0};
    tbl[1] = '{8'hA5, 1'b0, 1'b0, 0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 5};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 0};
    tbl[5] = '{8'h07, 1'b1, 1'b1, 0};
    tbl[6] = '{8'h07, 1'b0, 1'b1, 0};
    tbl[7] = '{8'h5A, 1'b0, 1'b1, 3};

    #12;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle line with EN=1 must not start a frame.
    repeat (3) send_bit(1'b1, 0);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    EN = 1'b0;

    send_bit(1'b0, 0);
    @(negedge clk);
    EN = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    idle(4);
    check("gap_hold_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h69 >> i), 0);
`ifdef SERIAL_DESHIFTER_PARITY_EN
    send_bit(1'b0, 0);
`endif
    begin
      exp_t e;
      model_data = 8'h69;
      e.ok = 1'b1;
      e.d  = 8'h69;
      sbq.push_back(e);
    end
    send_bit(1'b1, 0);
    idle(3);
    drain("drain_split_frame");

    // Frames back-to-back: no idle bit between stop and the next start.
    for (int v = 0; v < 8; v++) send_frame(tbl[v].pl, tbl[v].par, tbl[v].stp, tbl[v].gmax);
    idle(3);
    drain("drain_table");
    check("idle_after_table", {31'd0, busy}, 32'd0);

    // Mid-frame reset discards the partial 0xFF frame.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    EN    = 1'b0;
    #1;
    model_data = 8'h00;
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pulses", {30'd0, valid, frame_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h12, 1'b0, 1'b1, 0);
    idle(3);
    drain("drain_after_reset");
    check("final_data", {24'd0, data}, 32'd18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
